uart_rx_data40: RTL and testbench

Receive-side counterpart of the 40-bit UART packet transmitter. Deserialises 8N1 UART frames from the uart_rx pin and assembles five consecutive bytes, least-significant byte first, into one 40-bit word. Sits between the board RX pin and user logic. The packet format matches the transmitter: byte0 = Data40[7:0], and so on up to byte4 = Data40[39:32]. Self-contained: bit timing, byte framing, packet assembly and inter-byte timeout are all in this block.

---
 rtl/uart_rx_data40.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_data40.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_data40.sv
// 8N1 UART receiver assembling five bytes (LSB byte first) into a 40-bit word,
// with framing check and inter-byte timeout that discards partial packets.
module uart_rx_data40 #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        uart_rx,
  input  logic [2:0]  baud_set,
  output logic [39:0] Data40,
  output logic        Rx_Done,
  output logic        Frame_Err,
  output logic        Timeout_Err
);

  localparam logic [31:0] P9600   = CLK_FREQ / 32'd9600;
  localparam logic [31:0] P19200  = CLK_FREQ / 32'd19200;
  localparam logic [31:0] P38400  = CLK_FREQ / 32'd38400;
  localparam logic [31:0] P57600  = CLK_FREQ / 32'd57600;
  localparam logic [31:0] P115200 = CLK_FREQ / 32'd115200;
  localparam logic [31:0] TO_LAST = TIMEOUT_BITS - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      state, nstate;
  logic        rx_meta, rx_sync, rx_prev;
  logic        fall;
  logic [31:0] baud_sel, bit_per, cnt;
  logic [2:0]  bit_idx, idx;
  logic [7:0]  shift;
  logic [39:0] hold;
  logic [31:0] idle_sub, idle_bits;
  logic        tick, load_half, load_full, sample_bit, byte_ok, stop_bad;
  logic        to_run, sub_wrap;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev & ~rx_sync;
  assign tick = (cnt == '0);

  always_comb begin
    case (baud_set)
      3'd0:    baud_sel = P9600;
      3'd1:    baud_sel = P19200;
      3'd2:    baud_sel = P38400;
      3'd3:    baud_sel = P57600;
      default: baud_sel = P115200;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate     = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    sample_bit = 1'b0;
    byte_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          nstate    = S_START;
          load_half = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_sync) begin
            nstate    = S_DATA;
            load_full = 1'b1;
          end else begin
            nstate = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sample_bit = 1'b1;
          load_full  = 1'b1;
          if (bit_idx == 3'd7) nstate = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_sync) begin
            byte_ok = 1'b1;
            nstate  = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            nstate   = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // A falling edge suppresses the idle counter, so it beats a same-cycle timeout.
  assign to_run   = (state == S_IDLE) && (idx != '0) && !fall;
  assign sub_wrap = (idle_sub == bit_per - 32'd1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Data40      <= '0;
      Rx_Done     <= 1'b0;
      Frame_Err   <= 1'b0;
      Timeout_Err <= 1'b0;
      bit_per     <= '0;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      idx         <= '0;
      hold        <= '0;
      idle_sub    <= '0;
      idle_bits   <= '0;
    end else begin
      Rx_Done     <= 1'b0;
      Frame_Err   <= 1'b0;
      Timeout_Err <= 1'b0;

      if (state == S_IDLE) bit_per <= baud_sel;

      if (load_half)      cnt <= (baud_sel >> 1) - 32'd1;
      else if (load_full) cnt <= bit_per - 32'd1;
      else if (!tick)     cnt <= cnt - 32'd1;

      if (load_half) bit_idx <= '0;
      if (sample_bit) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (byte_ok) begin
        if (idx == 3'd4) begin
          Data40  <= {shift, hold[31:0]};
          Rx_Done <= 1'b1;
          idx     <= '0;
          hold    <= '0;
        end else begin
          case (idx)
            3'd0:    hold[7:0]   <= shift;
            3'd1:    hold[15:8]  <= shift;
            3'd2:    hold[23:16] <= shift;
            default: hold[31:24] <= shift;
          endcase
          idx <= idx + 3'd1;
        end
      end

      if (stop_bad) begin
        Frame_Err <= 1'b1;
        idx       <= '0;
        hold      <= '0;
      end

      if (!to_run) begin
        idle_sub  <= '0;
        idle_bits <= '0;
      end else if (sub_wrap) begin
        idle_sub <= '0;
        if (idle_bits == TO_LAST) begin
          Timeout_Err <= 1'b1;
          idx         <= '0;
          hold        <= '0;
          idle_bits   <= '0;
        end else begin
          idle_bits <= idle_bits + 32'd1;
        end
      end else begin
        idle_sub <= idle_sub + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_data40.sv
// Scoreboard bench for uart_rx_data40: stimulus queues expected events,
// a negedge monitor pops and compares whenever an output pulse appears.
`timescale 1ns/1ps
module tb_uart_rx_data40;

  localparam int unsigned CLKF = 1_843_200;
  localparam int K_DONE = 0;
  localparam int K_FERR = 1;
  localparam int K_TERR = 2;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        uart_rx;
  logic [2:0]  baud_set;
  logic [39:0] Data40;
  logic        Rx_Done, Frame_Err, Timeout_Err;

  typedef struct {
    int          kind;
    logic [39:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_start = 0;
  bit   stim_done = 1'b0;

  uart_rx_data40 #(.CLK_FREQ(CLKF), .TIMEOUT_BITS(20)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .uart_rx(uart_rx), .baud_set(baud_set),
    .Data40(Data40), .Rx_Done(Rx_Done), .Frame_Err(Frame_Err), .Timeout_Err(Timeout_Err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // 1_843_200 Hz divided by each baud rate
  function automatic int bits_for(input logic [2:0] bs);
    case (bs)
      3'd0:    return 192;
      3'd1:    return 96;
      3'd2:    return 48;
      3'd3:    return 32;
      default: return 16;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [39:0] data, input int c);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic idle_bits(input int nb);
    drive_bit(1'b1, nb * bits_for(baud_set));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit wiggle);
    int bp;
    bp = bits_for(baud_set);
    last_start = cyc;
    drive_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) begin
      if (wiggle && i == 4) baud_set = 3'd0;
      drive_bit(b[i], bp);
    end
    if (wiggle) baud_set = 3'd3;
    drive_bit(stop_v, bp);
    uart_rx = 1'b1;
  endtask

  task automatic send_packet(input logic [39:0] d);
    for (int i = 0; i < 5; i++) send_byte(d[8*i +: 8], 1'b1, 1'b0);
  endtask

  initial begin
    Reset_n  = 1'b0;
    uart_rx  = 1'b1;
    baud_set = 3'd4;
    repeat (5) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    drive_bit(1'b1, 3);

    push(K_DONE, 40'h5544332211, 0);
    send_packet(40'h5544332211);
    idle_bits(2);

    push(K_DONE, 40'h0102030405, 0);
    push(K_DONE, 40'hA5A5A5A5A5, 0);
    send_packet(40'h0102030405);
    send_packet(40'hA5A5A5A5A5);
    idle_bits(2);

    push(K_FERR, 40'h0, 0);
    send_byte(8'h10, 1'b1, 1'b0);
    send_byte(8'h20, 1'b1, 1'b0);
    send_byte(8'h30, 1'b0, 1'b0);
    idle_bits(2);
    push(K_DONE, 40'hEEDDCCBBAA, 0);
    send_packet(40'hEEDDCCBBAA);
    idle_bits(2);

    // Timeout lands 3 (sync+edge) + 8 (half bit) + 9*16 (to stop sample) + 20*16 cycles after start
    send_byte(8'h77, 1'b1, 1'b0);
    send_byte(8'h66, 1'b1, 1'b0);
    push(K_TERR, 40'hEEDDCCBBAA, last_start + 3 + 8 + 29 * 16);
    idle_bits(25);
    push(K_DONE, 40'h0123456789, 0);
    send_packet(40'h0123456789);
    idle_bits(2);

    drive_bit(1'b0, 5);
    idle_bits(2);
    push(K_DONE, 40'h13579BDF02, 0);
    send_packet(40'h13579BDF02);
    idle_bits(2);

    baud_set = 3'd7;
    idle_bits(1);
    push(K_DONE, 40'hFEDCBA9876, 0);
    send_packet(40'hFEDCBA9876);
    idle_bits(2);

    baud_set = 3'd3;
    idle_bits(1);
    push(K_DONE, 40'h8001FF7E3C, 0);
    send_byte(8'h3C, 1'b1, 1'b1);
    send_byte(8'h7E, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h80, 1'b1, 1'b0);
    idle_bits(2);
    baud_set = 3'd4;
    idle_bits(2);

    send_byte(8'h5A, 1'b1, 1'b0);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    Reset_n = 1'b0;
    drive_bit(1'b0, 4);
    uart_rx = 1'b1;
    Reset_n = 1'b1;
    idle_bits(12);
    push(K_DONE, 40'hDEADBEEF01, 0);
    send_packet(40'hDEADBEEF01);
    idle_bits(3);
    stim_done = 1'b1;
  end

  initial begin
    exp_t e;
    bit   rst_checked;
    int   kind;
    int   diff;
    rst_checked = 1'b0;
    while (!stim_done) begin
      @(negedge Clk);
      if (!Reset_n) begin
        if (!rst_checked) begin
          chk("reset_Data40", 64'(Data40), 64'h0);
          chk("reset_Rx_Done", 64'(Rx_Done), 64'h0);
          chk("reset_Frame_Err", 64'(Frame_Err), 64'h0);
          chk("reset_Timeout_Err", 64'(Timeout_Err), 64'h0);
          rst_checked = 1'b1;
        end
      end else begin
        rst_checked = 1'b0;
        if (Rx_Done || Frame_Err || Timeout_Err) begin
          if (int'(Rx_Done) + int'(Frame_Err) + int'(Timeout_Err) > 1) begin
            checks++;
            errors++;
            $display("FAIL multi_pulse actual=%b%b%b required=one-hot", Rx_Done, Frame_Err, Timeout_Err);
          end
          kind = Rx_Done ? K_DONE : (Frame_Err ? K_FERR : K_TERR);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual=kind%0d at cycle %0d required=none", kind, cyc);
          end else begin
            e = q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (e.kind == K_DONE && kind == K_DONE) chk("rx_data40", 64'(Data40), 64'(e.data));
            if (e.kind == K_TERR && kind == K_TERR) begin
              chk("data40_held_on_timeout", 64'(Data40), 64'(e.data));
              diff = cyc - e.cyc;
              checks++;
              if (diff < -1 || diff > 1) begin
                errors++;
                $display("FAIL timeout_cycle actual=%0d required=%0d", cyc, e.cyc);
              end
            end
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events actual=%0d pending required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
